// File: rtl/if_stage_fetch_buf_if.sv
// Fetch-stage bundle: split req/ack instruction SRAM bus, redirect port and IF->ID handshake.
// master = the fetch stage, slave = the SRAM / ID / redirect side.
interface if_stage_fetch_buf_if;
    logic         inst_sram_req;
    logic         inst_sram_wr;
    logic [1:0]   inst_sram_size;
    logic [3:0]   inst_sram_wstrb;
    logic [31:0]  inst_sram_addr;
    logic [31:0]  inst_sram_wdata;
    logic         inst_sram_addr_ok;
    logic         inst_sram_data_ok;
    logic [31:0]  inst_sram_rdata;
    logic         flush_valid;
    logic [31:0]  flush_target;
    logic         ID_allowin;
    logic         IF_to_ID_valid;
    logic [111:0] IF_to_ID_BUS;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata, IF_to_ID_valid, IF_to_ID_BUS,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
               flush_valid, flush_target, ID_allowin
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata, IF_to_ID_valid, IF_to_ID_BUS,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
               flush_valid, flush_target, ID_allowin
    );
endinterface

// File: rtl/if_stage_fetch_buf.sv
// IF stage with up to FIFO_DEPTH fetches in flight and an in-order buffer; an instruction reaches ID
// the cycle after its data_ok; requests stall when buffer + pending discards fill FIFO_DEPTH credits.
module if_stage_fetch_buf #(
    parameter logic [31:0] RESET_PC   = 32'h1C000000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    if_stage_fetch_buf_if.master  fb
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ex;
        logic        filled;
    } entry_t;

    entry_t          ent_q [FIFO_DEPTH];
    logic [31:0]     fetch_pc;
    logic [PW-1:0]   alloc_ptr;
    logic [PW-1:0]   fill_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   unfilled;
    logic [CW-1:0]   discard_cnt;
    logic            halted;

    logic [CW:0]     occupancy;
    logic            credit;
    logic            fetch_go;
    logic            aligned;
    logic            accept;
    logic            adef;
    logic            alloc;
    logic            pop;
    logic            fill;
    logic            drop;
    entry_t          head;

    // Stale responses still hold a credit, so in-flight traffic never exceeds FIFO_DEPTH.
    assign occupancy = {1'b0, count} + {1'b0, discard_cnt};
    assign credit    = occupancy < (CW+1)'(FIFO_DEPTH);
    assign fetch_go  = !reset && !fb.flush_valid && !halted && credit;
    assign aligned   = (fetch_pc[1:0] == 2'b00);
    assign accept    = fb.inst_sram_req && fb.inst_sram_addr_ok;
    assign adef      = fetch_go && !aligned;
    assign alloc     = accept || adef;
    assign fill      = fb.inst_sram_data_ok && !fb.flush_valid && (discard_cnt == '0);
    assign drop      = fb.inst_sram_data_ok && !fb.flush_valid && (discard_cnt != '0);
    assign head      = ent_q[rd_ptr];
    assign pop       = fb.IF_to_ID_valid && fb.ID_allowin;

    assign fb.inst_sram_req   = fetch_go && aligned;
    assign fb.inst_sram_wr    = 1'b0;
    assign fb.inst_sram_size  = 2'b10;
    assign fb.inst_sram_wstrb = 4'h0;
    assign fb.inst_sram_addr  = {fetch_pc[31:2], 2'b00};
    assign fb.inst_sram_wdata = 32'h0;

    assign fb.IF_to_ID_valid = !reset && (count != '0) && head.filled && !fb.flush_valid;
    assign fb.IF_to_ID_BUS   = {head.pc, head.inst, head.ex,
                                head.ex ? 15'h0008 : 15'h0000,
                                head.ex ? head.pc  : 32'h0};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            fetch_pc    <= RESET_PC;
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            unfilled    <= '0;
            discard_cnt <= '0;
            halted      <= 1'b0;
        end else if (fb.flush_valid) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_q[i].filled <= 1'b0;
            end
            fetch_pc    <= fb.flush_target;
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            unfilled    <= '0;
            halted      <= 1'b0;
            // A same-cycle data_ok retires one outstanding response, stale or live alike.
            discard_cnt <= discard_cnt + unfilled - CW'(fb.inst_sram_data_ok);
        end else begin
            if (alloc) begin
                ent_q[alloc_ptr] <= '{pc: fetch_pc, inst: 32'h0, ex: adef, filled: adef};
                alloc_ptr        <= alloc_ptr + PW'(1);
            end
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (adef) begin
                halted <= 1'b1;
            end
            if (fill) begin
                ent_q[fill_ptr].inst   <= fb.inst_sram_rdata;
                ent_q[fill_ptr].filled <= 1'b1;
                fill_ptr               <= fill_ptr + PW'(1);
            end
            if (drop) begin
                discard_cnt <= discard_cnt - CW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count    <= count + CW'(alloc) - CW'(pop);
            unfilled <= unfilled + CW'(accept) - CW'(fill);
        end
    end
endmodule

// File: tb/tb_if_stage_fetch_buf.sv
// Directed bench for if_stage_fetch_buf: in-order SRAM responder, pop/accept monitors,
// hand-computed expectations for streaming, full buffer, flush discard, ADEF and reset.
module tb_if_stage_fetch_buf;
    localparam logic [31:0] BASE = 32'h1C000000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_stage_fetch_buf_if ifc ();

    if_stage_fetch_buf #(.RESET_PC(BASE), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .fb    (ifc)
    );

    int total = 0;
    int bad   = 0;
    bit auto_resp = 1'b0;

    logic [31:0]  resp_q [$];
    logic [31:0]  acc    [$];
    logic [111:0] pops   [$];

    function automatic logic [31:0] rd(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] acc_at(input int i);
        return (acc.size() > i) ? acc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [111:0] pop_at(input int i);
        return (pops.size() > i) ? pops[i] : {112{1'b1}};
    endfunction

    task automatic chk(input string tag, input logic [111:0] act, input logic [111:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Accepts and pops are committed at the next posedge; inputs are stable from posedge+1 onward.
    always @(negedge clk) begin
        if (!reset) begin
            if (ifc.inst_sram_req && ifc.inst_sram_addr_ok) begin
                acc.push_back(ifc.inst_sram_addr);
                resp_q.push_back(ifc.inst_sram_addr);
            end
            if (ifc.IF_to_ID_valid && ifc.ID_allowin) begin
                pops.push_back(ifc.IF_to_ID_BUS);
            end
        end
    end

    task automatic give_resp();
        if (resp_q.size() > 0) begin
            ifc.inst_sram_data_ok = 1'b1;
            ifc.inst_sram_rdata   = rd(resp_q.pop_front());
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        ifc.inst_sram_data_ok = 1'b0;
        ifc.inst_sram_rdata   = 32'h0;
        if (auto_resp) give_resp();
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Leaves the caller in the first cycle after reset release.
    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        ifc.flush_valid = 1'b0;
        resp_q.delete();
        next_cycle();
        next_cycle();
        reset = 1'b0;
        acc.delete();
        pops.delete();
    endtask

    initial begin
        reset                 = 1'b1;
        ifc.inst_sram_addr_ok = 1'b0;
        ifc.inst_sram_data_ok = 1'b0;
        ifc.inst_sram_rdata   = 32'h0;
        ifc.flush_valid       = 1'b0;
        ifc.flush_target      = 32'h0;
        ifc.ID_allowin        = 1'b0;

        // Reset state and streaming
        next_cycle();
        next_cycle();
        sample();
        chk("rst_req", ifc.inst_sram_req, 0);
        chk("rst_vld", ifc.IF_to_ID_valid, 0);
        chk("rst_bus", ifc.IF_to_ID_BUS, 0);
        chk("const_bus", {ifc.inst_sram_wr, ifc.inst_sram_size, ifc.inst_sram_wstrb, ifc.inst_sram_wdata},
            {1'b0, 2'b10, 4'h0, 32'h0});
        next_cycle();
        reset = 1'b0;
        ifc.inst_sram_addr_ok = 1'b1;
        ifc.ID_allowin = 1'b1;
        auto_resp = 1'b1;
        acc.delete();
        pops.delete();
        sample();
        chk("first_req", ifc.inst_sram_req, 1);
        chk("first_addr", ifc.inst_sram_addr, BASE);
        repeat (11) begin
            next_cycle();
            sample();
        end
        chk("stream_acc_n", acc.size(), 12);
        chk("stream_pop_n", pops.size(), 10);
        for (int i = 0; i < 6; i++) begin
            chk("stream_addr", acc_at(i), BASE + 32'(4 * i));
            chk("stream_pc", pop_at(i)[111:80], BASE + 32'(4 * i));
            chk("stream_inst", pop_at(i)[79:48], rd(BASE + 32'(4 * i)));
        end

        // Full buffer blocks requests, then drains in order
        ifc.ID_allowin = 1'b0;
        do_reset();
        sample();
        repeat (7) begin
            next_cycle();
            sample();
        end
        chk("full_acc_n", acc.size(), 4);
        chk("full_req", ifc.inst_sram_req, 0);
        chk("full_count", dut.count, 4);
        chk("full_vld", ifc.IF_to_ID_valid, 1);
        next_cycle();
        ifc.ID_allowin = 1'b1;
        sample();
        chk("drain_req0", ifc.inst_sram_req, 0);
        chk("drain_pc0", ifc.IF_to_ID_BUS[111:80], BASE);
        next_cycle();
        sample();
        chk("drain_req1", ifc.inst_sram_req, 1);
        chk("drain_addr", ifc.inst_sram_addr, BASE + 32'h10);
        repeat (4) begin
            next_cycle();
            sample();
        end
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", pop_at(i)[111:80], BASE + 32'(4 * i));
        end

        // Flush with two responses outstanding
        auto_resp = 1'b0;
        do_reset();
        sample();
        next_cycle();
        sample();
        next_cycle();
        ifc.flush_valid  = 1'b1;
        ifc.flush_target = BASE + 32'h100;
        sample();
        chk("flush_noreq", ifc.inst_sram_req, 0);
        next_cycle();
        ifc.flush_valid = 1'b0;
        auto_resp = 1'b1;
        give_resp();
        sample();
        chk("disc_2", dut.discard_cnt, 2);
        chk("disc_vld0", ifc.IF_to_ID_valid, 0);
        chk("redir_addr", {ifc.inst_sram_req, ifc.inst_sram_addr}, {1'b1, BASE + 32'h100});
        next_cycle();
        sample();
        chk("disc_1", dut.discard_cnt, 1);
        chk("disc_vld1", ifc.IF_to_ID_valid, 0);
        next_cycle();
        sample();
        chk("disc_vld2", ifc.IF_to_ID_valid, 0);
        next_cycle();
        sample();
        chk("redir_vld", ifc.IF_to_ID_valid, 1);
        chk("redir_pc", ifc.IF_to_ID_BUS[111:80], BASE + 32'h100);
        chk("redir_inst", ifc.IF_to_ID_BUS[79:48], rd(BASE + 32'h100));

        // Misaligned redirect raises ADEF and halts fetch
        do_reset();
        ifc.flush_valid  = 1'b1;
        ifc.flush_target = BASE + 32'h102;
        sample();
        next_cycle();
        ifc.flush_valid = 1'b0;
        sample();
        chk("adef_noreq", ifc.inst_sram_req, 0);
        chk("adef_vld0", ifc.IF_to_ID_valid, 0);
        next_cycle();
        sample();
        chk("adef_vld", ifc.IF_to_ID_valid, 1);
        chk("adef_bus", ifc.IF_to_ID_BUS,
            {BASE + 32'h102, 32'h0, 1'b1, 15'h0008, BASE + 32'h102});
        next_cycle();
        sample();
        chk("adef_empty", ifc.IF_to_ID_valid, 0);
        repeat (3) begin
            next_cycle();
            sample();
        end
        chk("halt_req", ifc.inst_sram_req, 0);
        chk("halt_acc_n", acc.size(), 0);
        chk("halt_pop_n", pops.size(), 1);
        next_cycle();
        ifc.flush_valid  = 1'b1;
        ifc.flush_target = BASE + 32'h200;
        sample();
        next_cycle();
        ifc.flush_valid = 1'b0;
        sample();
        chk("resume_addr", {ifc.inst_sram_req, ifc.inst_sram_addr}, {1'b1, BASE + 32'h200});

        // Flush coinciding with data_ok and a pop
        do_reset();
        sample();
        repeat (3) begin
            next_cycle();
            sample();
        end
        next_cycle();
        ifc.flush_valid  = 1'b1;
        ifc.flush_target = BASE + 32'h300;
        sample();
        chk("cut_vld", ifc.IF_to_ID_valid, 0);
        next_cycle();
        ifc.flush_valid = 1'b0;
        sample();
        chk("cut_disc", dut.discard_cnt, 0);
        chk("cut_addr", {ifc.inst_sram_req, ifc.inst_sram_addr}, {1'b1, BASE + 32'h300});
        repeat (3) begin
            next_cycle();
            sample();
        end
        chk("cut_pop1", pop_at(1)[111:80], BASE + 32'h4);
        chk("cut_pop2", pop_at(2)[111:80], BASE + 32'h300);

        // Reset in the middle of traffic
        ifc.ID_allowin = 1'b0;
        auto_resp = 1'b0;
        do_reset();
        sample();
        next_cycle();
        sample();
        next_cycle();
        ifc.flush_valid  = 1'b1;
        ifc.flush_target = BASE + 32'h100;
        sample();
        next_cycle();
        ifc.flush_valid = 1'b0;
        give_resp();
        sample();
        repeat (3) begin
            next_cycle();
            sample();
        end
        chk("mid_count", dut.count, 3);
        chk("mid_disc", dut.discard_cnt, 1);
        chk("mid_req", ifc.inst_sram_req, 0);
        next_cycle();
        reset = 1'b1;
        resp_q.delete();
        sample();
        chk("rst_hold_req", ifc.inst_sram_req, 0);
        next_cycle();
        sample();
        chk("rst_count", dut.count, 0);
        chk("rst_disc", dut.discard_cnt, 0);
        chk("rst_req2", ifc.inst_sram_req, 0);
        chk("rst_vld2", ifc.IF_to_ID_valid, 0);
        next_cycle();
        reset = 1'b0;
        sample();
        chk("rel_addr", {ifc.inst_sram_req, ifc.inst_sram_addr}, {1'b1, BASE});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
